// File: rtl/pio_led_blink.sv
// pio_led_blink: Avalon-MM output PIO for an LED bank with readback,
// atomic set/clear and a shared-phase hardware blink engine.
module pio_led_blink #(
   parameter int unsigned      WIDTH       = 9,
   parameter int unsigned      DIV_W       = 24,
   parameter int unsigned      DIV_DEFAULT = 12499999,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             chipselect,
   input  logic [2:0]       address,
   input  logic             write_n,
   input  logic             read_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [WIDTH-1:0] out_port
);

   localparam logic [2:0] ADDR_DATA     = 3'd0;
   localparam logic [2:0] ADDR_BLINK_EN = 3'd1;
   localparam logic [2:0] ADDR_DIVIDER  = 3'd2;
   localparam logic [2:0] ADDR_SET      = 3'd3;
   localparam logic [2:0] ADDR_CLR      = 3'd4;
   localparam logic [2:0] ADDR_STATUS   = 3'd5;

   localparam logic [DIV_W-1:0] DIV_RESET = DIV_W'(DIV_DEFAULT);

   logic             wr_en;
   logic             rd_en;
   logic             div_wr;
   logic [WIDTH-1:0] wd_bits;
   logic [DIV_W-1:0] wd_div;

   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] blink_en_q;
   logic [DIV_W-1:0] divider_q;
   logic [DIV_W-1:0] cnt_q;
   logic             phase_q;
   logic [31:0]      rd_mux;

   // Upper writedata bits are architecturally ignored for narrow configurations.
   logic unused_writedata;
   assign unused_writedata = ^writedata;

   // Bus strobe decode; a write and a read may coincide in one cycle.
   assign wr_en   = chipselect & ~write_n;
   assign rd_en   = chipselect & ~read_n;
   assign div_wr  = wr_en && (address == ADDR_DIVIDER);
   assign wd_bits = writedata[WIDTH-1:0];
   assign wd_div  = writedata[DIV_W-1:0];

   // Control registers: DATA (with atomic set/clear), BLINK_EN, DIVIDER.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_q     <= RESET_VALUE;
         blink_en_q <= '0;
         divider_q  <= DIV_RESET;
      end else if (wr_en) begin
         case (address)
            ADDR_DATA:     data_q     <= wd_bits;
            ADDR_BLINK_EN: blink_en_q <= wd_bits;
            ADDR_DIVIDER:  divider_q  <= wd_div;
            ADDR_SET:      data_q     <= data_q | wd_bits;
            ADDR_CLR:      data_q     <= data_q & ~wd_bits;
            default:       ;
         endcase
      end
   end

   // Free-running half-period down-counter; a DIVIDER write restarts it in the on phase.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q   <= DIV_RESET;
         phase_q <= 1'b1;
      end else if (div_wr) begin
         cnt_q   <= wd_div;
         phase_q <= 1'b1;
      end else if (cnt_q == '0) begin
         cnt_q   <= divider_q;
         phase_q <= ~phase_q;
      end else begin
         cnt_q   <= cnt_q - DIV_W'(1);
      end
   end

   // Readback selection from pre-write register values.
   always_comb begin
      rd_mux = '0;
      case (address)
         ADDR_DATA:     rd_mux = 32'(data_q);
         ADDR_BLINK_EN: rd_mux = 32'(blink_en_q);
         ADDR_DIVIDER:  rd_mux = 32'(divider_q);
         ADDR_STATUS:   rd_mux = 32'({cnt_q, phase_q});
         default:       rd_mux = '0;
      endcase
   end

   // One-cycle read latency; readdata holds between reads.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readdata <= '0;
      end else if (rd_en) begin
         readdata <= rd_mux;
      end
   end

   // LED drive: blinking bits are gated by the shared phase.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_port <= RESET_VALUE;
      end else begin
         out_port <= data_q & (~blink_en_q | {WIDTH{phase_q}});
      end
   end

endmodule
